note_sequencer: RTL and testbench

Plays a short song by driving a square-wave speaker output from a table of (half-period, duration) note entries. It sequences two 8-bit down-counters: a pitch counter that is reloaded each half-period, and a beat counter that measures note length. The block sits between the song ROM (combinational read) and the board speaker/LED pins in the music lab top level. It owns the start/stop/done handshake for the song.

---
 rtl/music_pkg.sv | 14 +
 rtl/tone_timer.sv | 55 +++++
 rtl/note_sequencer.sv | 125 ++++++++++++
 tb/tb_note_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared types and constants for the note sequencer and its tone timer.
package music_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  localparam logic [7:0] PERIOD_REST = 8'd0;
  localparam logic [7:0] DUR_END     = 8'd0;

endpackage

// File: rtl/tone_timer.sv
// Reloadable 8-bit half-period down-counter driving the square-wave speaker flop.
module tone_timer
  import music_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] period,
  input  logic       en,
  input  logic       clear,
  output logic       spkr
);

  logic [7:0] cnt_q, cnt_d;
  logic [7:0] period_q, period_d;
  logic       spkr_q, spkr_d;

  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    spkr_d   = spkr_q;
    if (load) begin
      cnt_d    = period;
      period_d = period;
    end else if (en) begin
      // Reload wins over decrement, so the counter never underflows.
      if (cnt_q == 8'd0) begin
        cnt_d = period_q;
        if (period_q != PERIOD_REST) begin
          spkr_d = ~spkr_q;
        end
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end
    if (clear) begin
      spkr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= 8'd0;
      period_q <= 8'd0;
      spkr_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      spkr_q   <= spkr_d;
    end
  end

  assign spkr = spkr_q;

endmodule

// File: rtl/note_sequencer.sv
// Walks the note table, timing each note in beats and driving the tone timer.
module note_sequencer
  import music_pkg::*;
#(
  parameter int unsigned NUM_NOTES   = 8,
  parameter int unsigned BEAT_CYCLES = 16,
  localparam int unsigned AW = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_period,
  input  logic [7:0]    mem_dur,
  output logic          spkr,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] note_idx
);

  localparam logic [7:0]    BEAT_RELOAD = 8'(BEAT_CYCLES - 1);
  localparam logic [AW-1:0] LAST_IDX    = AW'(NUM_NOTES - 1);

  seq_state_t    state_q, state_d;
  logic [AW-1:0] note_idx_q, note_idx_d;
  logic [7:0]    beat_q, beat_d;
  logic [7:0]    dur_q, dur_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          tone_load_c, tone_en_c, tone_clear_c;

  always_comb begin
    state_d    = state_q;
    note_idx_d = note_idx_q;
    beat_d     = beat_q;
    dur_d      = dur_q;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d    = LOAD;
          note_idx_d = '0;
        end
      end
      LOAD: begin
        if (stop) begin
          state_d    = IDLE;
          note_idx_d = '0;
        end else begin
          beat_d  = BEAT_RELOAD;
          dur_d   = mem_dur;
          state_d = (mem_dur == DUR_END) ? DONE : PLAY;
        end
      end
      PLAY: begin
        if (beat_q == 8'd0) begin
          beat_d = BEAT_RELOAD;
          dur_d  = dur_q - 8'd1;
        end else begin
          beat_d = beat_q - 8'd1;
        end
        // Abort outranks the note boundary.
        if (stop) begin
          state_d    = IDLE;
          note_idx_d = '0;
        end else if (beat_q == 8'd0 && dur_q == 8'd1) begin
          if (note_idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            note_idx_d = note_idx_q + AW'(1);
            state_d    = LOAD;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy_d       = (state_d == LOAD) || (state_d == PLAY);
    done_d       = (state_d == DONE);
    tone_load_c  = (state_q == LOAD);
    tone_en_c    = (state_q == PLAY);
    tone_clear_c = (state_d != PLAY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      note_idx_q <= '0;
      beat_q     <= 8'd0;
      dur_q      <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      note_idx_q <= note_idx_d;
      beat_q     <= beat_d;
      dur_q      <= dur_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  tone_timer u_tone_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tone_load_c),
    .period (mem_period),
    .en     (tone_en_c),
    .clear  (tone_clear_c),
    .spkr   (spkr)
  );

  assign mem_addr = (state_q == IDLE) ? '0 : note_idx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign note_idx = note_idx_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench: a song-level model predicts every busy/done cycle of the sequencer.
module tb_note_sequencer;

  localparam int unsigned NN = 4;
  localparam int unsigned BC = 4;
  localparam int unsigned AW = 2;

  logic          clk = 1'b0;
  logic          rst, start, stop;
  logic [AW-1:0] mem_addr, note_idx;
  logic [7:0]    mem_period, mem_dur;
  logic          spkr, busy, done;

  logic [7:0] tbl_p [NN];
  logic [7:0] tbl_d [NN];

  assign mem_period = tbl_p[mem_addr];
  assign mem_dur    = tbl_d[mem_addr];

  always #5 clk = ~clk;

  note_sequencer #(.NUM_NOTES(NN), .BEAT_CYCLES(BC)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .mem_addr   (mem_addr),
    .mem_period (mem_period),
    .mem_dur    (mem_dur),
    .spkr       (spkr),
    .busy       (busy),
    .done       (done),
    .note_idx   (note_idx)
  );

  typedef struct {
    logic          busy;
    logic          spkr;
    logic          done;
    logic [AW-1:0] idx;
    logic          chk_addr;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Monitor: every cycle the DUT shows busy or done must match the next predicted cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (busy || done)) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output busy=%0b done=%0b idx=%0d", busy, done, note_idx);
      end else begin
        e = sb_q.pop_front();
        if (busy !== e.busy || spkr !== e.spkr || done !== e.done || note_idx !== e.idx ||
            (e.chk_addr && mem_addr !== e.idx)) begin
          errors++;
          $display("FAIL trace got busy=%0b spkr=%0b done=%0b idx=%0d addr=%0d exp busy=%0b spkr=%0b done=%0b idx=%0d",
                   busy, spkr, done, note_idx, mem_addr, e.busy, e.spkr, e.done, e.idx);
        end
      end
    end
  end

  // Song model: LOAD cycle per entry, dur*BC play cycles with tone from elapsed time, then DONE.
  task automatic build_trace(inout int stop_at, output int n, output int last_idx);
    exp_t t[$];
    int   i;
    bit   fin;
    i   = 0;
    fin = 1'b0;
    while (!fin) begin
      t.push_back('{busy: 1'b1, spkr: 1'b0, done: 1'b0, idx: AW'(i), chk_addr: 1'b1});
      if (tbl_d[i] == 8'd0) begin
        fin = 1'b1;
      end else begin
        for (int k = 0; k < int'(tbl_d[i]) * int'(BC); k++) begin
          t.push_back('{busy: 1'b1,
                        spkr: (tbl_p[i] != 8'd0) && (((k / (int'(tbl_p[i]) + 1)) % 2) == 1),
                        done: 1'b0, idx: AW'(i), chk_addr: 1'b0});
        end
        if (i == int'(NN) - 1) fin = 1'b1;
        else i++;
      end
    end
    t.push_back('{busy: 1'b0, spkr: 1'b0, done: 1'b1, idx: AW'(i), chk_addr: 1'b0});
    if (stop_at == -2) begin
      stop_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, t.size() - 2)) : -1;
    end
    if (stop_at >= 0) begin
      while (t.size() > stop_at + 1) void'(t.pop_back());
      last_idx = 0;
    end else begin
      last_idx = i;
    end
    n = t.size();
    foreach (t[j]) sb_q.push_back(t[j]);
  endtask

  task automatic check_idle(input string name, input int exp_idx);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_done"}, 32'(done), 32'd0);
    chk({name, "_spkr"}, 32'(spkr), 32'd0);
    chk({name, "_idx"}, 32'(note_idx), 32'(exp_idx));
    chk({name, "_addr"}, 32'(mem_addr), 32'd0);
  endtask

  task automatic run_song(input string name, input int stop_req, input bit poke);
    int n, last, stop_at;
    stop_at = stop_req;
    build_trace(stop_at, n, last);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (c == stop_at) stop = 1'b1;
      else if (poke && c < n - 1 && $urandom_range(0, 7) == 0) start = 1'b1;
      @(posedge clk);
      #1;
      stop  = 1'b0;
      start = 1'b0;
    end
    @(negedge clk);
    check_idle(name, last);
    chk({name, "_drain"}, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic set_tbl(input int p0, d0, p1, d1, p2, d2, p3, d3);
    tbl_p[0] = 8'(p0); tbl_d[0] = 8'(d0);
    tbl_p[1] = 8'(p1); tbl_d[1] = 8'(d1);
    tbl_p[2] = 8'(p2); tbl_d[2] = 8'(d2);
    tbl_p[3] = 8'(p3); tbl_d[3] = 8'(d3);
  endtask

  initial begin
    int n, last, s;
    rst   = 1'b1;
    start = 1'b1;
    stop  = 1'b0;
    set_tbl(2, 2, 7, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check_idle("in_reset", 0);
    #2 rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_idle("post_reset", 0);

    // Start together with stop is refused.
    start = 1'b1;
    stop  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    stop = 1'b0;
    @(negedge clk);
    check_idle("start_stop", 0);

    run_song("tone_term", -1, 1'b0);
    set_tbl(0, 3, 5, 1, 9, 0, 0, 0);
    run_song("rest_note", -1, 1'b0);
    set_tbl(1, 1, 0, 1, 2, 1, 3, 1);
    run_song("no_term", -1, 1'b1);
    set_tbl(2, 2, 7, 0, 0, 0, 0, 0);
    run_song("stop_mid", 3, 1'b0);
    run_song("stop_end", 8, 1'b0);

    // Asynchronous reset between edges while the tone is high.
    s = -1;
    build_trace(s, n, last);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_spkr", 32'(spkr), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_spkr", 32'(spkr), 32'd0);
    chk("async_idx", 32'(note_idx), 32'd0);
    sb_q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check_idle("after_async", 0);

    for (int it = 0; it < 30; it++) begin
      for (int e = 0; e < int'(NN); e++) begin
        tbl_p[e] = 8'($urandom_range(0, 4));
        tbl_d[e] = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
      end
      run_song("rand", -2, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
